// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU control stage: FSM states,
// instruction field positions, ALU control type and default widths.
package hack_pkg;

  localparam int PC_W   = 15;
  localparam int DATA_W = 16;

  // Instruction field bit positions
  localparam int IS_C    = 15;
  localparam int A_BIT   = 12;
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  localparam int DEST_A  = 5;
  localparam int DEST_D  = 4;
  localparam int DEST_M  = 3;
  localparam int JMP_HI  = 2;
  localparam int JMP_LO  = 0;

  // {zx,nx,zy,ny,f,no}
  typedef logic [5:0] alu_ctrl_t;

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    MEM_WAIT
  } state_t;

endpackage

// File: rtl/hack_jump_cond.sv
// Jump decision from the three jump bits and the ALU flags.
module hack_jump_cond (
  input  logic [2:0] j,
  input  logic       zr,
  input  logic       ng,
  output logic       jump
);

  // Negative, zero or strictly positive result, each enabled by one jump bit
  always_comb begin
    jump = (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);
  end

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multicycle Hack CPU control/datapath stage wrapped around an external ALU.
// Fetch uses valid/ready, data writes use req/ack.
// Optional macro HACK_CPU_RETIRE_CNT_EN adds a 32-bit retired instruction counter.
module hack_cpu_ctrl #(
  parameter int PC_W   = hack_pkg::PC_W,
  parameter int DATA_W = hack_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic [5:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic [PC_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0] mem_in,
  output logic [DATA_W-1:0] mem_out,
  output logic              mem_write,
  input  logic              mem_ack
`ifdef HACK_CPU_RETIRE_CNT_EN
  ,
  output logic [31:0]       retired_cnt
`endif
);

  import hack_pkg::*;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   wr_addr_q, wr_addr_d;
  logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
  logic              mem_write_q, mem_write_d;
  logic [DATA_W-1:0] mem_out_q, mem_out_d;

  logic              jump;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   jump_target;
  alu_ctrl_t         ctrl_bits;

  hack_jump_cond u_jump_cond (
    .j    (ir_q[JMP_HI:JMP_LO]),
    .zr   (alu_zr),
    .ng   (alu_ng),
    .jump (jump)
  );

  assign pc_inc      = pc_q + PC_W'(1);
  assign jump_target = jump ? a_q[PC_W-1:0] : pc_inc;
  assign ctrl_bits   = ir_q[COMP_HI:COMP_LO];

  assign instr_ready = (state_q == FETCH) && !reset;
  assign pc          = pc_q;
  assign alu_x       = d_q;
  assign alu_y       = ir_q[A_BIT] ? mem_in : a_q;
  assign alu_ctrl    = ctrl_bits;
  assign mem_addr    = (state_q == MEM_WAIT) ? wr_addr_q : a_q[PC_W-1:0];
  assign mem_out     = mem_out_q;
  assign mem_write   = mem_write_q;

  // State and architectural registers; reset clears everything immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FETCH;
      ir_q        <= '0;
      a_q         <= '0;
      d_q         <= '0;
      pc_q        <= '0;
      wr_addr_q   <= '0;
      pend_pc_q   <= '0;
      mem_write_q <= 1'b0;
      mem_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      d_q         <= d_d;
      pc_q        <= pc_d;
      wr_addr_q   <= wr_addr_d;
      pend_pc_q   <= pend_pc_d;
      mem_write_q <= mem_write_d;
      mem_out_q   <= mem_out_d;
    end
  end

  // Next-state and register updates; write targets and jump target use A before this cycle's write
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    a_d         = a_q;
    d_d         = d_q;
    pc_d        = pc_q;
    wr_addr_d   = wr_addr_q;
    pend_pc_d   = pend_pc_q;
    mem_write_d = mem_write_q;
    mem_out_d   = mem_out_q;
    case (state_q)
      FETCH: begin
        if (instr_valid && instr_ready) begin
          ir_d    = instr;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!ir_q[IS_C]) begin
          a_d     = ir_q;
          pc_d    = pc_inc;
          state_d = FETCH;
        end else begin
          if (ir_q[DEST_A]) a_d = alu_out;
          if (ir_q[DEST_D]) d_d = alu_out;
          if (ir_q[DEST_M]) begin
            wr_addr_d   = a_q[PC_W-1:0];
            mem_out_d   = alu_out;
            pend_pc_d   = jump_target;
            mem_write_d = 1'b1;
            state_d     = MEM_WAIT;
          end else begin
            pc_d    = jump_target;
            state_d = FETCH;
          end
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          mem_write_d = 1'b0;
          pc_d        = pend_pc_q;
          state_d     = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

`ifdef HACK_CPU_RETIRE_CNT_EN
  logic retire;

  assign retire = ((state_q == EXEC) && !(ir_q[IS_C] && ir_q[DEST_M])) ||
                  ((state_q == MEM_WAIT) && mem_ack);

  // Count every instruction that returns the FSM to FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_cnt <= '0;
    end else if (retire) begin
      retired_cnt <= retired_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Self-checking bench for hack_cpu_ctrl: behavioural ALU and data memory
// around the DUT, plus an instruction-level Hack reference model.
module tb_hack_cpu_ctrl;

  logic        clk;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [14:0] pc;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [5:0]  alu_ctrl;
  logic [15:0] alu_out;
  logic        alu_zr;
  logic        alu_ng;
  logic [14:0] mem_addr;
  logic [15:0] mem_in;
  logic [15:0] mem_out;
  logic        mem_write;
  logic        mem_ack;
`ifdef HACK_CPU_RETIRE_CNT_EN
  logic [31:0] retired_cnt;
`endif

  logic [15:0] dmem [0:32767];

  logic [15:0] m_a;
  logic [15:0] m_d;
  logic [14:0] m_pc;
  logic [31:0] m_ret;

  int tests = 0;
  int fails = 0;

  hack_cpu_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .alu_x       (alu_x),
    .alu_y       (alu_y),
    .alu_ctrl    (alu_ctrl),
    .alu_out     (alu_out),
    .alu_zr      (alu_zr),
    .alu_ng      (alu_ng),
    .mem_addr    (mem_addr),
    .mem_in      (mem_in),
    .mem_out     (mem_out),
    .mem_write   (mem_write),
    .mem_ack     (mem_ack)
`ifdef HACK_CPU_RETIRE_CNT_EN
    ,
    .retired_cnt (retired_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Standard Hack ALU
  function automatic logic [15:0] hackAlu(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
    logic [15:0] xx, yy, r;
    xx = c[5] ? 16'h0000 : x;
    xx = c[4] ? ~xx : xx;
    yy = c[3] ? 16'h0000 : y;
    yy = c[2] ? ~yy : yy;
    r  = c[1] ? (xx + yy) : (xx & yy);
    r  = c[0] ? ~r : r;
    return r;
  endfunction

  assign alu_out = hackAlu(alu_x, alu_y, alu_ctrl);
  assign alu_zr  = (alu_out == 16'h0000);
  assign alu_ng  = alu_out[15];
  assign mem_in  = dmem[mem_addr];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkFetch(input string tag);
    checkOutput({tag, "_ready"}, {31'd0, instr_ready}, 32'd1);
    checkOutput({tag, "_pc"}, {17'd0, pc}, {17'd0, m_pc});
    checkOutput({tag, "_D"}, {16'd0, alu_x}, {16'd0, m_d});
    checkOutput({tag, "_A"}, {17'd0, mem_addr}, {17'd0, m_a[14:0]});
    checkOutput({tag, "_mw"}, {31'd0, mem_write}, 32'd0);
`ifdef HACK_CPU_RETIRE_CNT_EN
    checkOutput({tag, "_ret"}, retired_cnt, m_ret);
`endif
  endtask

  task automatic modelReset();
    m_a   = 16'h0000;
    m_d   = 16'h0000;
    m_pc  = 15'h0000;
    m_ret = 32'd0;
  endtask

  // Feed one instruction from FETCH and follow it to retirement (entry and exit: #1 after posedge)
  task automatic applyStimulus(input logic [15:0] ins, input int ack_delay);
    logic [15:0] y, res;
    logic signed [15:0] sres;
    logic        jmp, wr;
    logic [14:0] tgt, waddr;
    checkOutput("accept_ready", {31'd0, instr_ready}, 32'd1);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    checkOutput("exec_ready", {31'd0, instr_ready}, 32'd0);
    wr = 1'b0;
    res = 16'h0000;
    waddr = m_a[14:0];
    if (ins[15]) begin
      y = ins[12] ? dmem[m_a[14:0]] : m_a;
      res = hackAlu(m_d, y, ins[11:6]);
      sres = res;
      checkOutput("exec_alu_x", {16'd0, alu_x}, {16'd0, m_d});
      checkOutput("exec_alu_y", {16'd0, alu_y}, {16'd0, y});
      checkOutput("exec_ctrl", {26'd0, alu_ctrl}, {26'd0, ins[11:6]});
      jmp = (ins[2] && sres < 0) || (ins[1] && sres == 0) || (ins[0] && sres > 0);
      tgt = jmp ? m_a[14:0] : m_pc + 15'd1;
      wr = ins[3];
      if (ins[5]) m_a = res;
      if (ins[4]) m_d = res;
    end else begin
      m_a = ins;
      tgt = m_pc + 15'd1;
    end
    @(posedge clk); #1;
    if (wr) begin
      for (int k = 0; k <= ack_delay; k++) begin
        checkOutput("wait_mw", {31'd0, mem_write}, 32'd1);
        checkOutput("wait_addr", {17'd0, mem_addr}, {17'd0, waddr});
        checkOutput("wait_data", {16'd0, mem_out}, {16'd0, res});
        checkOutput("wait_pc", {17'd0, pc}, {17'd0, m_pc});
        checkOutput("wait_ready", {31'd0, instr_ready}, 32'd0);
        if (k == ack_delay) begin
          mem_ack = 1'b1;
          dmem[waddr] = res;
        end
        @(posedge clk); #1;
      end
      mem_ack = 1'b0;
    end
    m_pc = tgt;
    m_ret = m_ret + 32'd1;
    checkFetch("retire");
  endtask

  task automatic stallCycles(input int n);
    instr_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      checkFetch("stall");
    end
  endtask

  initial begin
    logic [15:0] ins;
    for (int i = 0; i < 32768; i++) dmem[i] = 16'($urandom);
    reset = 1'b1;
    instr = 16'h0000;
    instr_valid = 1'b0;
    mem_ack = 1'b0;
    modelReset();

    #1;
    checkOutput("rst_pc", {17'd0, pc}, 32'd0);
    checkOutput("rst_D", {16'd0, alu_x}, 32'd0);
    checkOutput("rst_A", {17'd0, mem_addr}, 32'd0);
    checkOutput("rst_mw", {31'd0, mem_write}, 32'd0);
    checkOutput("rst_mout", {16'd0, mem_out}, 32'd0);
    checkOutput("rst_ready", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checkFetch("post_rst");

    // @5 ; D=A
    applyStimulus(16'h0005, 0);
    applyStimulus(16'hEC10, 0);
    checkOutput("tp1_pc", {17'd0, pc}, 32'd2);
    checkOutput("tp1_D", {16'd0, alu_x}, 32'd5);
    checkOutput("tp1_A", {17'd0, mem_addr}, 32'd5);

    // @7 ; D;JGT with D=5 jumps
    applyStimulus(16'h0007, 0);
    applyStimulus(16'hE301, 0);
    checkOutput("jgt_taken_pc", {17'd0, pc}, 32'd7);

    // @100 ; M=D with delayed ack
    applyStimulus(16'h0064, 0);
    applyStimulus(16'hE308, 3);
    checkOutput("mwr_pc", {17'd0, pc}, 32'd9);
    checkOutput("mwr_mem", {16'd0, dmem[100]}, 32'd5);

    // D=0 ; @7 ; D;JGT not taken ; D;JEQ taken
    applyStimulus(16'hEA90, 0);
    applyStimulus(16'h0007, 0);
    applyStimulus(16'hE301, 0);
    checkOutput("jgt_not_pc", {17'd0, pc}, 32'd12);
    applyStimulus(16'hE302, 0);
    checkOutput("jeq_pc", {17'd0, pc}, 32'd7);

    // pc wrap: jump to 0x7FFF then a plain A-instruction
    applyStimulus(16'h7FFF, 0);
    applyStimulus(16'hEA87, 0);
    checkOutput("wrap_pre_pc", {17'd0, pc}, 32'h7FFF);
    applyStimulus(16'h0000, 0);
    checkOutput("wrap_pc", {17'd0, pc}, 32'd0);

    stallCycles(5);

    // Asynchronous reset while waiting for a write ack
    applyStimulus(16'h0064, 0);
    applyStimulus(16'hEC10, 0);
    instr = 16'hE308;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("mw_before_rst", {31'd0, mem_write}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("arst_mw", {31'd0, mem_write}, 32'd0);
    checkOutput("arst_pc", {17'd0, pc}, 32'd0);
    checkOutput("arst_D", {16'd0, alu_x}, 32'd0);
    checkOutput("arst_A", {17'd0, mem_addr}, 32'd0);
    checkOutput("arst_ready", {31'd0, instr_ready}, 32'd0);
    @(posedge clk); #1;
    checkOutput("arst_hold_mw", {31'd0, mem_write}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checkFetch("arst_rel");

    // Randomised instruction stream
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) stallCycles(int'($urandom_range(1, 2)));
      if ($urandom_range(0, 2) == 0) ins = {1'b0, 15'($urandom)};
      else ins = {3'b111, 13'($urandom)};
      applyStimulus(ins, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
